bridge_rx_decoder: RTL
======================

// Module: bridge_rx_decoder
// PURPOSE
//  Consumes the byte stream from the UART receiver (axiid/axiiv) and decodes ASCII hex
//  command frames into single-cycle bus requests for the register/memory core chain.
//  Frames: 'R'+ADDR_HEX+EOL = read; 'W'+ADDR_HEX+DATA_HEX+EOL = write; EOL = CR or LF.
//  Malformed frames are dropped and flagged; decoding resumes at the next 'R'/'W'.
// PARAMETERS
//  ADDR_WIDTH  16  address width in bits; must be a multiple of 4 (NA = ADDR_WIDTH/4 hex chars)
//  DATA_WIDTH  16  write-data width in bits; must be a multiple of 4 (ND = DATA_WIDTH/4 hex chars)
// PORTS
//  clk      in   1           system clock
//  rst_n    in   1           asynchronous active-low reset
//  axiid    in   8           received byte
//  axiiv    in   1           axiid valid; one byte per asserted cycle, no back-pressure
//  addr_o   out  ADDR_WIDTH  decoded address, held until next request
//  data_o   out  DATA_WIDTH  decoded write data (0 for reads), held until next request
//  rw_o     out  1           1 = write, 0 = read; held until next request
//  valid_o  out  1           one-cycle pulse: addr_o/data_o/rw_o carry a new request
//  err_o    out  1           one-cycle pulse: a frame was discarded
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, nibble counter 0, shift registers 0; rst_n asserted mid-frame
//   aborts the frame silently (no err_o).
//  Only cycles with axiiv=1 advance state; axiid is ignored otherwise.
//  Hex chars: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46); each shifts its nibble in MSB-first.
//  States:
//   IDLE: 'R' -> ADDR (rw=0); 'W' -> ADDR (rw=1); CR/LF ignored (covers CRLF pairs);
//    any other byte -> err_o, stay IDLE.
//   ADDR: hex -> shift into addr, count; at NA-th nibble -> DATA if rw else EOL.
//   DATA: hex -> shift into data, count; at ND-th nibble -> EOL.
//   EOL: CR or LF -> latch outputs, valid_o=1 next cycle, -> IDLE.
//  Error: non-hex byte in ADDR/DATA, or non-EOL byte in EOL -> err_o pulse next cycle,
//   discard frame, -> IDLE. Exception: an 'R'/'W' error byte restarts a new frame
//   (-> ADDR) in the same cycle, still pulsing err_o.
//  Latency: valid_o rises exactly 1 clk after the cycle the terminating EOL byte is presented.
//  Outputs update only with valid_o; the shift registers are internal, so a partially
//   received frame never disturbs addr_o/data_o/rw_o.
//  Reads drive data_o = 0.
//  valid_o and err_o are never high in the same cycle.
//  Back-to-back bytes on consecutive cycles are fully supported; a new 'R'/'W' may arrive
//   the cycle after EOL.
//  Counter width: $clog2(max(NA,ND)+1); the counter clears on every state change.
// CONFIGURATION
//  BRIDGE_RX_LOWERCASE_EN defined: additionally accept 'r','w' as commands and 'a'-'f' as
//   hex, with identical values to the uppercase characters.
//  Not defined: lowercase bytes are invalid and follow the error rules above.
// TESTING
//  "R1234\r" -> one valid_o; addr_o=0x1234, rw_o=0, data_o=0; latency 1 clk after '\r'.
//  "W0010BEEF\r\n" -> one valid_o; addr_o=0x0010, data_o=0xBEEF, rw_o=1; trailing '\n' ignored.
//  "R12G4\r" -> err_o pulse at 'G', no valid_o; a following "R0001\n" -> addr_o=0x0001.
//  "W12R0005\r" -> err_o at 'R', then valid_o with addr_o=0x0005, rw_o=0.
//  rst_n pulsed low after "W00" -> outputs 0, no err_o; "R00FF\r" -> addr_o=0x00FF.
//  "r00ff\r" -> with BRIDGE_RX_LOWERCASE_EN: valid_o, addr_o=0x00FF;
//   without the macro: err_o, no valid_o.

Source files
------------

// File: rtl/bridge_rx_decoder.sv
`default_nettype none
// ============================================================================
// bridge_rx_decoder : ASCII hex command frames (R/W) -> single-cycle bus requests
// Option macro BRIDGE_RX_LOWERCASE_EN: accept lowercase commands and hex digits
// Revision: 1.0
// ============================================================================
module bridge_rx_decoder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            axiid,
  input  logic                  axiiv,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  output logic                  err_o
);

  localparam int c_na   = ADDR_WIDTH / 4;
  localparam int c_nd   = DATA_WIDTH / 4;
  localparam int c_nmax = (c_na > c_nd) ? c_na : c_nd;
  localparam int CW     = $clog2(c_nmax + 1);
  localparam logic [CW-1:0] c_na_last = CW'(c_na - 1);
  localparam logic [CW-1:0] c_nd_last = CW'(c_nd - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_EOL  = 2'd3
  } state_t;

  state_t                r_state, w_next_state;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr_sh, w_addr_sh_next;
  logic [DATA_WIDTH-1:0] r_data_sh, w_data_sh_next;
  logic                  r_rw, w_rw_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_rwo, r_valid, r_err;

  logic       w_is_hex, w_is_eol, w_is_r, w_is_w, w_cmd;
  logic [3:0] w_nib;
  logic       w_fire, w_err, w_start;

  // Byte classification
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'd0;
    if (axiid >= 8'h30 && axiid <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = axiid[3:0];
    end else if (axiid >= 8'h41 && axiid <= 8'h46) begin
      w_is_hex = 1'b1;
      w_nib    = axiid[3:0] + 4'd9;
    end
`ifdef BRIDGE_RX_LOWERCASE_EN
    else if (axiid >= 8'h61 && axiid <= 8'h66) begin
      w_is_hex = 1'b1;
      w_nib    = axiid[3:0] + 4'd9;
    end
`endif
  end

`ifdef BRIDGE_RX_LOWERCASE_EN
  assign w_is_r = (axiid == 8'h52) || (axiid == 8'h72);
  assign w_is_w = (axiid == 8'h57) || (axiid == 8'h77);
`else
  assign w_is_r = (axiid == 8'h52);
  assign w_is_w = (axiid == 8'h57);
`endif
  assign w_is_eol = (axiid == 8'h0D) || (axiid == 8'h0A);
  assign w_cmd    = w_is_r || w_is_w;

  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_addr_sh_next = r_addr_sh;
    w_data_sh_next = r_data_sh;
    w_rw_next      = r_rw;
    w_fire         = 1'b0;
    w_err          = 1'b0;
    w_start        = 1'b0;
    if (axiiv) begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd)          w_start = 1'b1;
          else if (!w_is_eol) w_err   = 1'b1;
        end
        S_ADDR: begin
          if (w_is_hex) begin
            w_addr_sh_next = ADDR_WIDTH'({r_addr_sh, w_nib});
            if (r_cnt == c_na_last) begin
              w_next_state = r_rw ? S_DATA : S_EOL;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CW'(1);
            end
          end else begin
            w_err   = 1'b1;
            w_start = w_cmd;
          end
        end
        S_DATA: begin
          if (w_is_hex) begin
            w_data_sh_next = DATA_WIDTH'({r_data_sh, w_nib});
            if (r_cnt == c_nd_last) begin
              w_next_state = S_EOL;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CW'(1);
            end
          end else begin
            w_err   = 1'b1;
            w_start = w_cmd;
          end
        end
        default: begin
          if (w_is_eol) begin
            w_fire       = 1'b1;
            w_next_state = S_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_err   = 1'b1;
            w_start = w_cmd;
          end
        end
      endcase

      // A command byte always opens a fresh frame, even when it is also an error byte
      if (w_start) begin
        w_next_state   = S_ADDR;
        w_cnt_next     = '0;
        w_rw_next      = w_is_w;
        w_addr_sh_next = '0;
        w_data_sh_next = '0;
      end else if (w_err) begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_rw      <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_next;
      r_addr_sh <= w_addr_sh_next;
      r_data_sh <= w_data_sh_next;
      r_rw      <= w_rw_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_rwo   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_fire;
      r_err   <= w_err;
      if (w_fire) begin
        r_addr <= r_addr_sh;
        r_data <= r_rw ? r_data_sh : '0;
        r_rwo  <= r_rw;
      end
    end
  end

  assign addr_o  = r_addr;
  assign data_o  = r_data;
  assign rw_o    = r_rwo;
  assign valid_o = r_valid;
  assign err_o   = r_err;

endmodule
`default_nettype wire
